multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM sequencer for the multi-cycle MIPS datapath. It shares one PC/IR/ALU/memory
//  path across the FETCH..WB steps and issues per-state control strobes.
//  It decodes the same instruction set as the single-cycle decoder:
//    R-type: add/addu/sub/subu/and/or/nor/slt/sltu/sll
//    I-type: addi/ori/lui/lw/sw/beq   J-type: j/jal
//  Memory accesses use a req/ack handshake with a timeout. The block also counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles per memory access with mem_ack=0; 0 disables the timeout
//  CNT_W        32  width of the retired-instruction counter
// PORTS
//  clk        in   1      clock, rising edge
//  rstn       in   1      async reset, active low
//  Op         in   6      IR[31:26], stable from DECODE until the next FETCH completes
//  Funct      in   6      IR[5:0]
//  Zero       in   1      ALU zero flag, sampled in BRANCH
//  mem_ack    in   1      memory completes the access in this cycle
//  mem_req    out  1      memory access request
//  MemWrite   out  1      access is a write (valid with mem_req)
//  PCWrite    out  1      PC load enable
//  IRWrite    out  1      IR load enable
//  RegWrite   out  1      register file write enable
//  ALUSrcA    out  1      0=PC, 1=rs
//  ALUSrcB    out  2      00=rt, 01=const 4, 10=ext imm
//  EXTOp      out  1      1=sign-extend, 0=zero-extend
//  ALUOp      out  4      1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 SLTU, 7 SLL, 8 NOR/LUI(by Op), 0 NOP
//  NPCOp      out  2      00 PLUS4, 01 BRANCH, 10 JUMP
//  GPRSel     out  2      00 rd, 01 rt, 10 $31
//  WDSel      out  2      00 ALU, 01 MEM, 10 PC
//  instr_done out  1      1-cycle pulse in the final state of each instruction
//  instr_cnt  out  CNT_W  retired-instruction count; wraps at all-ones to 0
//  err        out  1      sticky; set by an illegal instruction or a memory timeout
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. Timeout counter 0, instr_cnt 0.
//  Outputs are a combinational decode of the state register plus Op/Funct (Moore + IR decode).
//  States and transitions:
//   IDLE    -> FETCH unconditionally.
//   FETCH   mem_req=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD.
//           On mem_ack: IRWrite=1, PCWrite=1 (NPCOp=PLUS4), go to DECODE. Otherwise hold.
//   DECODE  go to EXEC (R-type, addi, ori, lui), MEMADR (lw/sw), BRANCH (beq) or JUMP (j/jal).
//           Any other Op/Funct goes to ERR.
//   EXEC    ALUSrcA=1. ALUSrcB=00 for R-type, else 10. ALUOp per instruction.
//           EXTOp=1 only for addi. Next state RWB.
//   RWB     RegWrite=1, WDSel=00, GPRSel=00 for R-type / 01 for I-type.
//           ALU controls held as in EXEC. instr_done=1. Next state FETCH.
//   MEMADR  ALUSrcA=1, ALUSrcB=10, EXTOp=1, ALUOp=ADD. Next state MEMRD (lw) or MEMWR (sw).
//   MEMRD   mem_req=1, address controls held. On mem_ack go to MEMWB.
//   MEMWB   RegWrite=1, GPRSel=01, WDSel=01, instr_done=1. Next state FETCH.
//   MEMWR   mem_req=1, MemWrite=1, address controls held.
//           On mem_ack: instr_done=1, go to FETCH.
//   BRANCH  ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, NPCOp=01, PCWrite=Zero, instr_done=1.
//           Next state FETCH.
//   JUMP    NPCOp=10, PCWrite=1, instr_done=1. For jal also RegWrite=1, GPRSel=10, WDSel=10.
//           Next state FETCH.
//   ERR     all strobes 0, err=1. Stays in ERR until rstn.
//  Latency with zero-wait memory:
//   R/addi/ori/lui 4 cycles, lw 5, sw 4, beq 3, j/jal 3.
//   Each wait cycle in FETCH/MEMRD/MEMWR adds 1.
//  Timeout: the counter increments each cycle a mem state sees mem_ack=0 and clears when it leaves.
//   When the counter reaches MEM_TIMEOUT and mem_ack is still 0, go to ERR next cycle.
//   mem_ack in that same cycle wins (no error).
//  instr_cnt increments on every instr_done cycle and wraps all-ones -> 0.
//  Async rstn mid-instruction: immediate return to IDLE with outputs 0. No partial PC/reg/mem write survives.
// TESTING
//  1. add (Op=0, Funct=0x20), ack every cycle -> FETCH,DECODE,EXEC,RWB.
//     RegWrite only in RWB; instr_cnt=1 after cycle 4.
//  2. lw, mem_ack delayed 3 cycles in MEMRD -> 8 cycles total.
//     MemWrite=0; WDSel=01 and GPRSel=01 in MEMWB.
//  3. beq with Zero=1 then Zero=0 -> PCWrite=1/NPCOp=01 for the first, PCWrite=0 for the second.
//     Both take 3 cycles.
//  4. jal -> JUMP state: PCWrite=1, NPCOp=10, RegWrite=1, GPRSel=10, WDSel=10.
//  5. MEM_TIMEOUT=15, mem_ack held 0 in FETCH -> ERR after 16 FETCH cycles.
//     err=1, strobes 0 until rstn.
//  6. Op=0x3F -> ERR from DECODE. Also: rstn low during MEMWR -> IDLE, mem_req=0 at once.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore FSM sequencer for the multi-cycle MIPS datapath
//
// Purpose: steps one shared PC/IR/ALU/memory path through FETCH..WB for the
// supported R/I/J instructions, issuing per-state control strobes. Memory
// accesses use a req/ack handshake with a wait-cycle timeout; retired
// instructions are counted.
//
// Ports:
//   clk, rstn             clock (rising edge), async active-low reset
//   Op, Funct             IR[31:26] / IR[5:0], stable from DECODE to next FETCH
//   Zero                  ALU zero flag, used in BRANCH
//   mem_ack / mem_req     memory handshake; MemWrite qualifies mem_req as a write
//   PCWrite, IRWrite      PC / IR load enables
//   RegWrite              register file write enable
//   ALUSrcA, ALUSrcB      ALU operand selects (A: 0=PC 1=rs; B: 00=rt 01=4 10=imm)
//   EXTOp                 1=sign-extend immediate
//   ALUOp                 1 ADD 2 SUB 3 AND 4 OR 5 SLT 6 SLTU 7 SLL 8 NOR/LUI 0 NOP
//   NPCOp                 00 PLUS4, 01 BRANCH, 10 JUMP
//   GPRSel, WDSel         write register (rd/rt/$31) and write data (ALU/MEM/PC)
//   instr_done            pulse in the final state of each instruction
//   instr_cnt             retired-instruction count, wraps
//   err                   sticky error (illegal instruction or memory timeout)
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             EXTOp,
  output logic [3:0]       ALUOp,
  output logic [1:0]       NPCOp,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             err
);

  localparam logic [3:0] S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,
                         S_EXEC   = 4'd3,  S_RWB    = 4'd4,  S_MEMADR = 4'd5,
                         S_MEMRD  = 4'd6,  S_MEMWB  = 4'd7,  S_MEMWR  = 4'd8,
                         S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_ERR    = 4'd11;

  localparam logic [5:0] OP_R   = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_ORI = 6'h0d,
                         OP_LUI = 6'h0f, OP_LW  = 6'h23, OP_SW  = 6'h2b;

  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2,
                         ALU_AND = 4'd3, ALU_OR  = 4'd4, ALU_SLT = 4'd5,
                         ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_NOR = 4'd8;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [3:0]    state, state_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [3:0]    dec_aluop;
  logic          dec_legal;
  logic          is_r;
  logic          mem_state;
  logic          timeout_hit;

  assign is_r = (Op == OP_R);

  // Instruction decode: ALU operation and legality of the current Op/Funct.
  always_comb begin
    dec_aluop = ALU_NOP;
    dec_legal = 1'b1;
    case (Op)
      OP_R: begin
        case (Funct)
          6'h20, 6'h21: dec_aluop = ALU_ADD;
          6'h22, 6'h23: dec_aluop = ALU_SUB;
          6'h24:        dec_aluop = ALU_AND;
          6'h25:        dec_aluop = ALU_OR;
          6'h27:        dec_aluop = ALU_NOR;
          6'h2a:        dec_aluop = ALU_SLT;
          6'h2b:        dec_aluop = ALU_SLTU;
          6'h00:        dec_aluop = ALU_SLL;
          default:      dec_legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: dec_aluop = ALU_ADD;
      OP_ORI:                dec_aluop = ALU_OR;
      OP_LUI:                dec_aluop = ALU_NOR;
      OP_BEQ:                dec_aluop = ALU_SUB;
      OP_J, OP_JAL:          dec_aluop = ALU_NOP;
      default:               dec_legal = 1'b0;
    endcase
  end

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  // The counter holds the number of wait cycles already spent; once it has
  // reached the limit, one more unacknowledged cycle aborts. An ack in that
  // same cycle still completes the access.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_state && !mem_ack &&
                       (tcnt == TW'(MEM_TIMEOUT));

  always_comb begin
    tcnt_d = '0;
    if ((MEM_TIMEOUT != 0) && mem_state && !mem_ack && !timeout_hit)
      tcnt_d = tcnt + 1'b1;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_legal) state_d = S_ERR;
        else begin
          case (Op)
            OP_R, OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXEC;
            OP_LW, OP_SW:                  state_d = S_MEMADR;
            OP_BEQ:                        state_d = S_BRANCH;
            OP_J, OP_JAL:                  state_d = S_JUMP;
            default:                       state_d = S_ERR;
          endcase
        end
      end
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ack) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ack) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
    if (timeout_hit) state_d = S_ERR;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      instr_cnt <= '0;
    end else begin
      state <= state_d;
      tcnt  <= tcnt_d;
      if (instr_done) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    EXTOp      = 1'b0;
    ALUOp      = ALU_NOP;
    NPCOp      = 2'b00;
    GPRSel     = 2'b00;
    WDSel      = 2'b00;
    instr_done = 1'b0;
    err        = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        IRWrite = mem_ack;
        PCWrite = mem_ack;
      end
      S_EXEC, S_RWB: begin
        ALUSrcA = 1'b1;
        ALUSrcB = is_r ? 2'b00 : 2'b10;
        ALUOp   = dec_aluop;
        EXTOp   = (Op == OP_ADDI);
        if (state == S_RWB) begin
          RegWrite   = 1'b1;
          GPRSel     = is_r ? 2'b00 : 2'b01;
          instr_done = 1'b1;
        end
      end
      S_MEMADR, S_MEMRD, S_MEMWR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        EXTOp   = 1'b1;
        ALUOp   = ALU_ADD;
        mem_req = (state != S_MEMADR);
        if (state == S_MEMWR) begin
          MemWrite   = 1'b1;
          instr_done = mem_ack;
        end
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        GPRSel     = 2'b01;
        WDSel      = 2'b01;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_SUB;
        NPCOp      = 2'b01;
        PCWrite    = Zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        NPCOp      = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        if (Op == OP_JAL) begin
          RegWrite = 1'b1;
          GPRSel   = 2'b10;
          WDSel    = 2'b10;
        end
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard testbench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk;
  logic       rstn;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ack;
  logic       mem_req, MemWrite, PCWrite, IRWrite, RegWrite, ALUSrcA, EXTOp;
  logic [1:0] ALUSrcB, NPCOp, GPRSel, WDSel;
  logic [3:0] ALUOp;
  logic       instr_done, err;
  logic [2:0] instr_cnt;

  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(3)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .ALUOp(ALUOp),
    .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel), .instr_done(instr_done),
    .instr_cnt(instr_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] obs_vec;
  assign obs_vec = {mem_req, MemWrite, PCWrite, IRWrite, RegWrite, ALUSrcA,
                    ALUSrcB, EXTOp, ALUOp, NPCOp, GPRSel, WDSel};

  typedef struct {
    string       tag;
    int          cycles;
    logic [18:0] fin;
    int          memw;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cnt_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] pk(input bit mr, input bit mw, input bit pcw,
                                     input bit irw, input bit rw, input bit asa,
                                     input logic [1:0] asb, input bit ext,
                                     input logic [3:0] aop, input logic [1:0] npc,
                                     input logic [1:0] gpr, input logic [1:0] wd);
    return {mr, mw, pcw, irw, rw, asa, asb, ext, aop, npc, gpr, wd};
  endfunction

  // Entered and left at posedge+1 of a FETCH cycle.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input bit z, input int fw, input int mw, input int cycles,
                           input logic [18:0] fin, input int memw);
    exp_t e;
    int cyc, acc, wc, need, rw_early, irw, mwc;
    bit done;
    logic [18:0] fv;
    e.tag = tag; e.cycles = cycles; e.fin = fin; e.memw = memw;
    sb.push_back(e);
    Op = op; Funct = fn; Zero = z;
    cyc = 0; acc = 0; wc = 0; rw_early = 0; irw = 0; mwc = 0; done = 0; fv = '0;
    while (!done && cyc < 100) begin
      cyc++;
      if (mem_req) begin
        need = (acc == 0) ? fw : mw;
        if (wc >= need) begin mem_ack = 1'b1; acc++; wc = 0; end
        else begin mem_ack = 1'b0; wc++; end
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      if (IRWrite) irw++;
      if (MemWrite) mwc++;
      if (instr_done) begin
        done = 1;
        fv = obs_vec;
      end else begin
        if (RegWrite) rw_early++;
        @(posedge clk); #1;
      end
    end
    e = sb.pop_front();
    chk({e.tag, "_done"}, 32'(done), 32'd1);
    chk({e.tag, "_cycles"}, cyc, e.cycles);
    chk({e.tag, "_final"}, fv, e.fin);
    chk({e.tag, "_regw_early"}, rw_early, 0);
    chk({e.tag, "_irwrite"}, irw, 1);
    chk({e.tag, "_memwrite"}, mwc, e.memw);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    cnt_model = (cnt_model + 1) % 8;
    chk({e.tag, "_cnt"}, instr_cnt, cnt_model);
    chk({e.tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    mem_ack = 1'b0;
    rstn = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_strobes", obs_vec, 0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;
    cnt_model = 0;
    @(posedge clk); #1;
  endtask

  // Drives an opcode through FETCH with immediate ack, then expects ERR after DECODE.
  task automatic illegal(input string tag, input logic [5:0] op, input logic [5:0] fn);
    Op = op; Funct = fn; mem_ack = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b0;
    chk({tag, "_decode_err"}, err, 0);
    @(posedge clk); #1;
    chk({tag, "_err"}, err, 1);
    chk({tag, "_strobes"}, obs_vec, 0);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_sticky"}, err, 1);
    chk({tag, "_done"}, instr_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fcnt, guard;
    rstn = 1'b0; Op = '0; Funct = '0; Zero = 1'b0; mem_ack = 1'b0;
    do_reset();

    run_instr("add",   6'h00, 6'h20, 0, 0, 0, 4, pk(0,0,0,0,1,1,2'b00,0,4'd1,2'b00,2'b00,2'b00), 0);
    run_instr("lw",    6'h23, 6'h00, 0, 0, 3, 8, pk(0,0,0,0,1,0,2'b00,0,4'd0,2'b00,2'b01,2'b01), 0);
    run_instr("beq_t", 6'h04, 6'h00, 1, 0, 0, 3, pk(0,0,1,0,0,1,2'b00,0,4'd2,2'b01,2'b00,2'b00), 0);
    run_instr("beq_n", 6'h04, 6'h00, 0, 0, 0, 3, pk(0,0,0,0,0,1,2'b00,0,4'd2,2'b01,2'b00,2'b00), 0);
    run_instr("jal",   6'h03, 6'h00, 0, 0, 0, 3, pk(0,0,1,0,1,0,2'b00,0,4'd0,2'b10,2'b10,2'b10), 0);
    run_instr("sw",    6'h2b, 6'h00, 0, 1, 2, 7, pk(1,1,0,0,0,1,2'b10,1,4'd1,2'b00,2'b00,2'b00), 3);
    run_instr("addi",  6'h08, 6'h00, 0, 0, 0, 4, pk(0,0,0,0,1,1,2'b10,1,4'd1,2'b00,2'b01,2'b00), 0);
    run_instr("ori",   6'h0d, 6'h00, 0, 0, 0, 4, pk(0,0,0,0,1,1,2'b10,0,4'd4,2'b00,2'b01,2'b00), 0);
    run_instr("lui",   6'h0f, 6'h00, 0, 0, 0, 4, pk(0,0,0,0,1,1,2'b10,0,4'd8,2'b00,2'b01,2'b00), 0);
    run_instr("sll",   6'h00, 6'h00, 0, 0, 0, 4, pk(0,0,0,0,1,1,2'b00,0,4'd7,2'b00,2'b00,2'b00), 0);
    run_instr("j",     6'h02, 6'h00, 0, 0, 0, 3, pk(0,0,1,0,0,0,2'b00,0,4'd0,2'b10,2'b00,2'b00), 0);
    run_instr("sub",   6'h00, 6'h22, 0, 0, 0, 4, pk(0,0,0,0,1,1,2'b00,0,4'd2,2'b00,2'b00,2'b00), 0);
    run_instr("nor",   6'h00, 6'h27, 0, 0, 0, 4, pk(0,0,0,0,1,1,2'b00,0,4'd8,2'b00,2'b00,2'b00), 0);
    run_instr("sltu",  6'h00, 6'h2b, 0, 0, 0, 4, pk(0,0,0,0,1,1,2'b00,0,4'd6,2'b00,2'b00,2'b00), 0);
    // Ack on the last allowed wait cycle must still complete normally.
    run_instr("add_w15", 6'h00, 6'h20, 0, 15, 0, 19, pk(0,0,0,0,1,1,2'b00,0,4'd1,2'b00,2'b00,2'b00), 0);

    // Fetch timeout: ack never arrives.
    Op = 6'h00; Funct = 6'h20; mem_ack = 1'b0;
    fcnt = 0; guard = 0;
    while (guard < 40) begin
      guard++;
      @(negedge clk);
      if (err) break;
      if (mem_req) fcnt++;
      @(posedge clk); #1;
    end
    chk("tmo_fetch_cycles", fcnt, 16);
    chk("tmo_err", err, 1);
    chk("tmo_strobes", obs_vec, 0);
    mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("tmo_sticky", err, 1);
    chk("tmo_strobes_late", obs_vec, 0);

    do_reset();
    illegal("ill_op", 6'h3f, 6'h00);
    do_reset();
    illegal("ill_funct", 6'h00, 6'h01);
    do_reset();

    // Async reset in the middle of a store.
    Op = 6'h2b; Funct = 6'h00; mem_ack = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_memreq", mem_req, 1);
    chk("rst_mid_memwrite", MemWrite, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_strobes", obs_vec, 0);
    chk("rst_mid_done", instr_done, 0);
    chk("rst_mid_cnt", instr_cnt, 0);
    @(negedge clk);
    rstn = 1'b1;
    cnt_model = 0;
    @(posedge clk); #1;
    run_instr("add_after_rst", 6'h00, 6'h21, 0, 0, 0, 4, pk(0,0,0,0,1,1,2'b00,0,4'd1,2'b00,2'b00,2'b00), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
